// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the writeback stage, the MEM/WB register and the forwarding unit.
package pipeline_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_core.sv
// Integer register array with a hard-wired zero register and two raw, unbypassed read ports.
module regfile_core #(
  parameter int XLEN = pipeline_pkg::XLEN,
  parameter int NREG = pipeline_pkg::NREG,
  parameter int AW = pipeline_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  import pipeline_pkg::REG_ZERO;

  // Entry 0 is cleared on reset and never written, so it folds to a constant.
  logic [XLEN-1:0] regs [0:NREG-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != AW'(REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == AW'(REG_ZERO)) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == AW'(REG_ZERO)) ? '0 : regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// bypasses it to the decode read ports in the same cycle and counts retired writes.
module wb_regfile #(
  parameter int XLEN = pipeline_pkg::XLEN,
  parameter int NREG = pipeline_pkg::NREG,
  parameter int AW = pipeline_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MEM_WB_RegWrite,
  input  logic            MEM_WB_MemtoReg,
  input  logic [AW-1:0]   MEM_WB_rd,
  input  logic [XLEN-1:0] MEM_WB_ALU_Out,
  input  logic [XLEN-1:0] MEM_WB_Read_Data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic [XLEN-1:0] WB_Data,
  output logic            WB_Valid,
  output logic [XLEN-1:0] Retired_Writes
);
  import pipeline_pkg::REG_ZERO;

  logic [XLEN-1:0] raw1;
  logic [XLEN-1:0] raw2;

  // WB_Valid is a pure qualifier on the MEM/WB payload: there is no back-pressure,
  // every cycle it is high the write commits on the next rising edge.
  assign WB_Data  = MEM_WB_MemtoReg ? MEM_WB_Read_Data : MEM_WB_ALU_Out;
  assign WB_Valid = !reset && MEM_WB_RegWrite && (MEM_WB_rd != AW'(REG_ZERO));

  regfile_core #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_core (
    .clk    (clk),
    .reset  (reset),
    .we     (WB_Valid),
    .waddr  (MEM_WB_rd),
    .wdata  (WB_Data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  // Bypass the in-flight write so decode never sees the stale array value.
  always_comb begin
    ReadData1 = raw1;
    ReadData2 = raw2;
    if (WB_Valid && MEM_WB_rd == rs1) ReadData1 = WB_Data;
    if (WB_Valid && MEM_WB_rd == rs2) ReadData2 = WB_Data;
    if (reset || rs1 == AW'(REG_ZERO)) ReadData1 = '0;
    if (reset || rs2 == AW'(REG_ZERO)) ReadData2 = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Retired_Writes <= '0;
    end else if (WB_Valid) begin
      Retired_Writes <= Retired_Writes + XLEN'(1);
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, reset and wrap sequences, and random traffic
// against an array-based reference model. A second 8-bit instance exercises counter wrap.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic        we, m2r;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] alu, rdat;
  logic [63:0] rd1, rd2, wbd, ret;
  logic        wbv;
  logic [7:0]  rd1_8, rd2_8, wbd_8, ret_8;
  logic        wbv_8;

  logic [63:0] model_regs [0:31];
  logic [63:0] model_count;
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .MEM_WB_RegWrite(we), .MEM_WB_MemtoReg(m2r), .MEM_WB_rd(rd),
    .MEM_WB_ALU_Out(alu), .MEM_WB_Read_Data(rdat),
    .rs1(rs1), .rs2(rs2),
    .ReadData1(rd1), .ReadData2(rd2), .WB_Data(wbd), .WB_Valid(wbv),
    .Retired_Writes(ret)
  );

  wb_regfile #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset),
    .MEM_WB_RegWrite(we), .MEM_WB_MemtoReg(m2r), .MEM_WB_rd(rd),
    .MEM_WB_ALU_Out(alu[7:0]), .MEM_WB_Read_Data(rdat[7:0]),
    .rs1(rs1), .rs2(rs2),
    .ReadData1(rd1_8), .ReadData2(rd2_8), .WB_Data(wbd_8), .WB_Valid(wbv_8),
    .Retired_Writes(ret_8)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_wb();
    return m2r ? rdat : alu;
  endfunction

  function automatic logic model_valid();
    return !reset && we && rd != 5'd0;
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] idx);
    if (reset || idx == 5'd0) return 64'd0;
    if (model_valid() && rd == idx) return model_wb();
    return model_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
    model_count = 64'd0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] e1, e2, ew;
    e1 = model_read(rs1);
    e2 = model_read(rs2);
    ew = model_wb();
    check({tag, " rd1"}, rd1, e1);
    check({tag, " rd2"}, rd2, e2);
    check({tag, " wbd"}, wbd, ew);
    check({tag, " wbv"}, {63'd0, wbv}, {63'd0, model_valid()});
    check({tag, " cnt"}, ret, model_count);
    check({tag, " rd1_8"}, {56'd0, rd1_8}, {56'd0, e1[7:0]});
    check({tag, " rd2_8"}, {56'd0, rd2_8}, {56'd0, e2[7:0]});
    check({tag, " cnt_8"}, {56'd0, ret_8}, {56'd0, model_count[7:0]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic m, input logic [4:0] d,
                       input logic [63:0] a, input logic [63:0] r,
                       input logic [4:0] s1, input logic [4:0] s2);
    we = w; m2r = m; rd = d; alu = a; rdat = r; rs1 = s1; rs2 = s2;
    #1;
  endtask

  // Advance one edge, update the model with whatever commit the driven inputs imply.
  task automatic tick();
    @(posedge clk);
    if (model_valid()) begin
      model_regs[rd] = model_wb();
      model_count = model_count + 64'd1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic we; logic m2r; logic [4:0] rd; logic [63:0] alu; logic [63:0] rdat;
    logic [4:0] rs1; logic [4:0] rs2;
    logic [63:0] e1; logic [63:0] e2; logic [63:0] ewb; logic ev; logic [63:0] ecnt;
  } vec_t;

  vec_t tab [9];

  initial begin
    // we m2r rd alu rdat rs1 rs2 | exp rd1 rd2 wb valid count-after-edge
    tab[0] = '{1'b1, 1'b0, 5'd5, 64'h1234, 64'h9999, 5'd5, 5'd0, 64'h1234, 64'h0,    64'h1234, 1'b1, 64'd1};
    tab[1] = '{1'b1, 1'b1, 5'd6, 64'h1111, 64'hDEAD, 5'd5, 5'd6, 64'h1234, 64'hDEAD, 64'hDEAD, 1'b1, 64'd2};
    tab[2] = '{1'b1, 1'b0, 5'd7, 64'hABCD, 64'h0,    5'd7, 5'd7, 64'hABCD, 64'hABCD, 64'hABCD, 1'b1, 64'd3};
    tab[3] = '{1'b1, 1'b0, 5'd0, 64'hFFFF, 64'h0,    5'd0, 5'd6, 64'h0,    64'hDEAD, 64'hFFFF, 1'b0, 64'd3};
    tab[4] = '{1'b0, 1'b0, 5'd9, 64'h55,   64'h0,    5'd9, 5'd7, 64'h0,    64'hABCD, 64'h55,   1'b0, 64'd3};
    tab[5] = '{1'b0, 1'b0, 5'd1, 64'h0,    64'h0,    5'd9, 5'd6, 64'h0,    64'hDEAD, 64'h0,    1'b0, 64'd3};
    tab[6] = '{1'b1, 1'b0, 5'd5, 64'hAAAA, 64'h0,    5'd5, 5'd5, 64'hAAAA, 64'hAAAA, 64'hAAAA, 1'b1, 64'd4};
    tab[7] = '{1'b1, 1'b1, 5'd5, 64'h0,    64'hBBBB, 5'd5, 5'd7, 64'hBBBB, 64'hABCD, 64'hBBBB, 1'b1, 64'd5};
    tab[8] = '{1'b0, 1'b0, 5'd5, 64'h0,    64'h0,    5'd5, 5'd7, 64'hBBBB, 64'hABCD, 64'h0,    1'b0, 64'd5};

    we = 1'b0; m2r = 1'b0; rd = '0; alu = '0; rdat = '0; rs1 = '0; rs2 = '0;
    reset = 1'b1;
    model_reset();
    #2;
    // Reset state, including a pending write request that must be masked.
    drive(1'b1, 1'b0, 5'd4, 64'h77, 64'h0, 5'd4, 5'd4);
    check("rst rd1", rd1, 64'd0);
    check("rst rd2", rd2, 64'd0);
    check("rst wbv", {63'd0, wbv}, 64'd0);
    check("rst wbd", wbd, 64'h77);
    check("rst cnt", ret, 64'd0);
    do_reset();

    // ---------------- directed table ----------------
    for (int i = 0; i < 9; i++) begin
      drive(tab[i].we, tab[i].m2r, tab[i].rd, tab[i].alu, tab[i].rdat, tab[i].rs1, tab[i].rs2);
      check($sformatf("vec%0d rd1", i), rd1, tab[i].e1);
      check($sformatf("vec%0d rd2", i), rd2, tab[i].e2);
      check($sformatf("vec%0d wbd", i), wbd, tab[i].ewb);
      check($sformatf("vec%0d wbv", i), {63'd0, wbv}, {63'd0, tab[i].ev});
      tick();
      check($sformatf("vec%0d cnt", i), ret, tab[i].ecnt);
    end

    // ---------------- asynchronous reset mid-write ----------------
    drive(1'b1, 1'b0, 5'd3, 64'hC0DE, 64'h0, 5'd3, 5'd5);
    check("prewr rd1", rd1, 64'hC0DE);
    #2;
    reset = 1'b1;
    #1;
    check("async rd1", rd1, 64'd0);
    check("async rd2", rd2, 64'd0);
    check("async wbv", {63'd0, wbv}, 64'd0);
    check("async cnt", ret, 64'd0);
    check("async cnt_8", {56'd0, ret_8}, 64'd0);
    check("async wbd", wbd, 64'hC0DE);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd3, 64'h0, 64'h0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd3, 64'h0, 64'h0, 5'(i), 5'(32 - i));
      check($sformatf("clr x%0d", i), rd1, 64'd0);
      check($sformatf("clr2 x%0d", 32 - i), rd2, 64'd0);
    end
    check("clr cnt", ret, 64'd0);

    // ---------------- random traffic ----------------
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d,
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    // ---------------- counter wrap on the 8-bit instance ----------------
    do_reset();
    for (int n = 0; n < 256; n++) begin
      drive(1'b1, 1'b0, 5'($urandom_range(1, 31)), {$urandom, $urandom}, 64'h0, 5'd0, 5'd0);
      if (n == 255) check("wrap pre cnt_8", {56'd0, ret_8}, 64'd255);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0);
    check("wrap cnt_8", {56'd0, ret_8}, 64'd0);
    check("wrap cnt", ret, 64'd256);
    check_model("wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
